// File: rtl/frame_sync_detector_pkg.sv
// Shared types and constants for the frame sync detector.
//   state_t : framing state (HUNT / VERIFY / LOCK)
//   COUNT_W : width of the in-frame bit position counter
package frame_sync_detector_pkg;

  localparam int unsigned COUNT_W = 8;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } state_t;

endpackage

// File: rtl/sync_matcher.sv
// Serial shift register and sync word comparator.
//   clk   : clock, shifts on rising edge
//   reset : asynchronous, active-low
//   in    : serial data bit, MSB of the sync word arrives first
//   match : combinational; high when the newest SYNC_W bits, including the
//           bit on `in` right now, equal SYNC_PAT
module sync_matcher #(
  parameter int unsigned       SYNC_W   = 4,
  parameter logic [SYNC_W-1:0] SYNC_PAT = 4'b1001
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic match
);

  logic [SYNC_W-1:0] sr;
  logic [SYNC_W-1:0] window;

  // Oldest bit falls off the top; the current bit is included without waiting an edge.
  assign window = SYNC_W'({sr, in});
  assign match  = (window == SYNC_PAT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr <= '0;
    end else begin
      sr <= window;
    end
  end

endmodule

// File: rtl/frame_sync_detector.sv
// Serial frame synchroniser: hunts for a sync word, confirms it at the expected
// frame position, then extracts fixed-width payload words while locked.
//   clk       : clock, all state on rising edge
//   reset     : asynchronous, active-low
//   in        : serial data bit
//   count     : bit position within the frame (0 on the first payload bit)
//   frame     : one-cycle pulse per accepted sync while (or on becoming) locked
//   out       : last completed payload word, MSB received first
//   out_valid : one-cycle pulse when out is updated
//   flag      : high while locked
module frame_sync_detector
  import frame_sync_detector_pkg::*;
#(
  parameter int unsigned       SYNC_W    = 4,
  parameter logic [SYNC_W-1:0] SYNC_PAT  = 4'b1001,
  parameter int unsigned       FRAME_LEN = 16,
  parameter int unsigned       WORD_W    = 4,
  parameter int unsigned       CONFIRM   = 2,
  parameter int unsigned       MISS      = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in,
  output logic [COUNT_W-1:0] count,
  output logic               frame,
  output logic [WORD_W-1:0]  out,
  output logic               out_valid,
  output logic               flag
);

  localparam int unsigned HITS_W = $clog2(CONFIRM + 1);
  localparam int unsigned MISS_W = $clog2(MISS + 1);
  localparam int unsigned WBIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [COUNT_W-1:0] LAST_POS  = COUNT_W'(FRAME_LEN - 1);
  localparam logic [COUNT_W-1:0] PAY_LAST  = COUNT_W'(FRAME_LEN - SYNC_W - 1);
  localparam logic [HITS_W-1:0]  CONFIRM_V = HITS_W'(CONFIRM);
  localparam logic [MISS_W-1:0]  MISS_V    = MISS_W'(MISS);
  localparam logic [WBIT_W-1:0]  WBIT_LAST = WBIT_W'(WORD_W - 1);

  state_t              state, state_nxt;
  logic [COUNT_W-1:0]  count_nxt;
  logic [HITS_W-1:0]   hits, hits_nxt;
  logic [MISS_W-1:0]   misses, misses_nxt;
  logic [WORD_W-1:0]   word, word_nxt;
  logic [WBIT_W-1:0]   wbit, wbit_nxt;
  logic [WORD_W-1:0]   out_nxt;
  logic                out_valid_nxt;
  logic                frame_nxt;
  logic                flag_nxt;

  logic                match;
  logic                check;
  logic [COUNT_W-1:0]  count_inc;

  sync_matcher #(
    .SYNC_W   (SYNC_W),
    .SYNC_PAT (SYNC_PAT)
  ) u_matcher (
    .clk   (clk),
    .reset (reset),
    .in    (in),
    .match (match)
  );

  // The expected sync position is the last bit of the frame.
  assign check     = (count == LAST_POS);
  assign count_inc = check ? '0 : count + 1'b1;

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    hits_nxt      = hits;
    misses_nxt    = misses;
    word_nxt      = word;
    wbit_nxt      = wbit;
    out_nxt       = out;
    out_valid_nxt = 1'b0;
    frame_nxt     = 1'b0;

    case (state)
      HUNT: begin
        count_nxt = '0;
        if (match) begin
          hits_nxt = HITS_W'(1);
          if (CONFIRM == 1) begin
            state_nxt  = LOCK;
            misses_nxt = '0;
          end else begin
            state_nxt = VERIFY;
          end
        end
      end

      VERIFY: begin
        count_nxt = count_inc;
        if (check) begin
          if (match) begin
            hits_nxt = hits + 1'b1;
            if (hits + 1'b1 == CONFIRM_V) begin
              state_nxt  = LOCK;
              misses_nxt = '0;
              frame_nxt  = 1'b1;
            end
          end else begin
            state_nxt = HUNT;
            count_nxt = '0;
            hits_nxt  = '0;
          end
        end
      end

      LOCK: begin
        count_nxt = count_inc;
        // Payload bits never coincide with the check position.
        if (count <= PAY_LAST) begin
          word_nxt = WORD_W'({word, in});
          if (wbit == WBIT_LAST) begin
            out_nxt       = word_nxt;
            out_valid_nxt = 1'b1;
            wbit_nxt      = '0;
          end else begin
            wbit_nxt = wbit + 1'b1;
          end
        end
        if (check) begin
          if (match) begin
            misses_nxt = '0;
            frame_nxt  = 1'b1;
          end else if (misses + 1'b1 == MISS_V) begin
            state_nxt  = HUNT;
            count_nxt  = '0;
            misses_nxt = '0;
            hits_nxt   = '0;
          end else begin
            misses_nxt = misses + 1'b1;
          end
        end
      end

      default: begin
        state_nxt = HUNT;
        count_nxt = '0;
      end
    endcase

    // A partial word never survives outside LOCK.
    if (state_nxt != LOCK) begin
      word_nxt = '0;
      wbit_nxt = '0;
    end

    flag_nxt = (state_nxt == LOCK);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= HUNT;
      count     <= '0;
      hits      <= '0;
      misses    <= '0;
      word      <= '0;
      wbit      <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      frame     <= 1'b0;
      flag      <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      hits      <= hits_nxt;
      misses    <= misses_nxt;
      word      <= word_nxt;
      wbit      <= wbit_nxt;
      out       <= out_nxt;
      out_valid <= out_valid_nxt;
      frame     <= frame_nxt;
      flag      <= flag_nxt;
    end
  end

endmodule

// File: tb/tb_frame_sync_detector.sv
// Self-checking bench for frame_sync_detector: a default-parameter instance
// driven from a per-frame vector table plus hand sequences, and a byte-wide
// instance (8-bit sync, 24-bit frame).
module tb_frame_sync_detector;

  logic        clk;
  logic        rst1, in1;
  logic [7:0]  count1;
  logic        frame1, ov1, flag1;
  logic [3:0]  out1;

  logic        rst2, in2;
  logic [7:0]  count2;
  logic        frame2, ov2, flag2;
  logic [7:0]  out2;

  int checks = 0;
  int errors = 0;

  frame_sync_detector u_dut (
    .clk       (clk),
    .reset     (rst1),
    .in        (in1),
    .count     (count1),
    .frame     (frame1),
    .out       (out1),
    .out_valid (ov1),
    .flag      (flag1)
  );

  frame_sync_detector #(
    .SYNC_W    (8),
    .SYNC_PAT  (8'hA7),
    .FRAME_LEN (24),
    .WORD_W    (8),
    .CONFIRM   (2),
    .MISS      (3)
  ) u_dut8 (
    .clk       (clk),
    .reset     (rst2),
    .in        (in2),
    .count     (count2),
    .frame     (frame2),
    .out       (out2),
    .out_valid (ov2),
    .flag      (flag2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // One 16-bit frame (sync then payload) and what it should produce.
  typedef struct packed {
    logic [3:0]  sync;
    logic [11:0] payload;
    logic        e_flag;
    logic [3:0]  e_frames;
    logic [3:0]  e_valids;
    logic [11:0] e_words;
    logic [3:0]  e_out;
    logic [7:0]  e_count;
  } rec_t;

  rec_t tbl [12];

  function automatic rec_t mk(input logic [3:0] s, input logic [11:0] p, input logic f,
                              input logic [3:0] nf, input logic [3:0] nv,
                              input logic [11:0] w, input logic [3:0] o, input logic [7:0] c);
    rec_t r;
    r.sync     = s;
    r.payload  = p;
    r.e_flag   = f;
    r.e_frames = nf;
    r.e_valids = nv;
    r.e_words  = w;
    r.e_out    = o;
    r.e_count  = c;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive1(input logic b);
    in1 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic drive2(input logic b);
    in2 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic run1(input int idx);
    rec_t        r;
    logic [15:0] bits;
    logic [11:0] words;
    int          nf, nv;
    r     = tbl[idx];
    bits  = {r.sync, r.payload};
    words = '0;
    nf    = 0;
    nv    = 0;
    for (int b = 15; b >= 0; b--) begin
      drive1(bits[b]);
      if (frame1) nf++;
      if (ov1) begin
        nv++;
        words = {words[7:0], out1};
      end
    end
    chk($sformatf("rec%0d_flag", idx),   32'(flag1),  32'(r.e_flag));
    chk($sformatf("rec%0d_frames", idx), 32'(nf),     32'(r.e_frames));
    chk($sformatf("rec%0d_valids", idx), 32'(nv),     32'(r.e_valids));
    chk($sformatf("rec%0d_words", idx),  32'(words),  32'(r.e_words));
    chk($sformatf("rec%0d_out", idx),    32'(out1),   32'(r.e_out));
    chk($sformatf("rec%0d_count", idx),  32'(count1), 32'(r.e_count));
  endtask

  task automatic run2(input int idx, input logic [7:0] s, input logic [15:0] p,
                      input logic ef, input int enf, input int env,
                      input logic [15:0] ew, input logic [7:0] ecnt);
    logic [23:0] bits;
    logic [15:0] words;
    int          nf, nv;
    bits  = {s, p};
    words = '0;
    nf    = 0;
    nv    = 0;
    for (int b = 23; b >= 0; b--) begin
      drive2(bits[b]);
      if (frame2) nf++;
      if (ov2) begin
        nv++;
        words = {words[7:0], out2};
      end
    end
    chk($sformatf("w8_frm%0d_flag", idx),   32'(flag2),  32'(ef));
    chk($sformatf("w8_frm%0d_frames", idx), 32'(nf),     32'(enf));
    chk($sformatf("w8_frm%0d_valids", idx), 32'(nv),     32'(env));
    chk($sformatf("w8_frm%0d_words", idx),  32'(words),  32'(ew));
    chk($sformatf("w8_frm%0d_count", idx),  32'(count2), 32'(ecnt));
  endtask

  initial begin
    //               sync   payload  flg  frm   val   words    out   count
    tbl[0]  = mk(4'h9, 12'hA5C, 1'b0, 4'd0, 4'd0, 12'h000, 4'h0, 8'd12);
    tbl[1]  = mk(4'h9, 12'hA5C, 1'b1, 4'd1, 4'd3, 12'hA5C, 4'hC, 8'd12);
    tbl[2]  = mk(4'h9, 12'h3C7, 1'b1, 4'd1, 4'd3, 12'h3C7, 4'h7, 8'd12);
    tbl[3]  = mk(4'hD, 12'hA5C, 1'b1, 4'd0, 4'd3, 12'hA5C, 4'hC, 8'd12);
    tbl[4]  = mk(4'h9, 12'h5A3, 1'b1, 4'd1, 4'd3, 12'h5A3, 4'h3, 8'd12);
    tbl[5]  = mk(4'hD, 12'hA5C, 1'b1, 4'd0, 4'd3, 12'hA5C, 4'hC, 8'd12);
    tbl[6]  = mk(4'hD, 12'hA5C, 1'b1, 4'd0, 4'd3, 12'hA5C, 4'hC, 8'd12);
    tbl[7]  = mk(4'hD, 12'h000, 1'b0, 4'd0, 4'd0, 12'h000, 4'hC, 8'd0);
    tbl[8]  = mk(4'h9, 12'h000, 1'b0, 4'd0, 4'd0, 12'h000, 4'hC, 8'd12);
    tbl[9]  = mk(4'h9, 12'h5A3, 1'b1, 4'd1, 4'd3, 12'h5A3, 4'h3, 8'd12);
    tbl[10] = mk(4'h9, 12'hA5C, 1'b0, 4'd0, 4'd0, 12'h000, 4'h0, 8'd12);
    tbl[11] = mk(4'h9, 12'hA5C, 1'b1, 4'd1, 4'd3, 12'hA5C, 4'hC, 8'd12);

    rst1 = 1'b0;
    rst2 = 1'b0;
    in1  = 1'b0;
    in2  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count",  32'(count1), 32'd0);
    chk("rst_flag",   32'(flag1),  32'd0);
    chk("rst_out",    32'(out1),   32'd0);
    chk("rst_ovalid", 32'(ov1),    32'd0);
    chk("rst_frame",  32'(frame1), 32'd0);
    chk("rst8_count", 32'(count2), 32'd0);
    chk("rst8_out",   32'(out2),   32'd0);
    @(negedge clk);
    rst1 = 1'b1;

    // Lock, payload extraction, single/double misses, loss of lock, relock.
    for (int i = 0; i < 10; i++) run1(i);

    // Reset pulse mid-payload while locked.
    drive1(1'b1); drive1(1'b0); drive1(1'b0); drive1(1'b1);
    drive1(1'b1); drive1(1'b0); drive1(1'b1); drive1(1'b0);
    chk("midrst_pre_out",    32'(out1),  32'hA);
    chk("midrst_pre_ovalid", 32'(ov1),   32'd1);
    drive1(1'b0);
    chk("midrst_pre_flag",   32'(flag1), 32'd1);
    #3;
    rst1 = 1'b0;
    #1;
    chk("midrst_count",  32'(count1), 32'd0);
    chk("midrst_flag",   32'(flag1),  32'd0);
    chk("midrst_out",    32'(out1),   32'd0);
    chk("midrst_ovalid", 32'(ov1),    32'd0);
    chk("midrst_frame",  32'(frame1), 32'd0);
    @(posedge clk);
    #1;
    chk("midrst_hold_count", 32'(count1), 32'd0);
    @(negedge clk);
    rst1 = 1'b1;
    for (int i = 10; i < 12; i++) run1(i);

    // False sync seen in HUNT is rejected at the next expected position.
    rst1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst1 = 1'b1;
    begin
      logic [7:0] fake;
      fake = 8'h69;
      for (int b = 7; b >= 0; b--) drive1(fake[b]);
    end
    repeat (12) drive1(1'b0);
    chk("false_verify_count", 32'(count1), 32'd12);
    chk("false_verify_flag",  32'(flag1),  32'd0);
    repeat (2) drive1(1'b0);
    chk("false_verify_count14", 32'(count1), 32'd14);
    repeat (2) drive1(1'b0);
    chk("false_reject_count", 32'(count1), 32'd0);
    repeat (4) drive1(1'b0);
    chk("false_hunt_count", 32'(count1), 32'd0);
    chk("false_hunt_flag",  32'(flag1),  32'd0);
    chk("false_hunt_frame", 32'(frame1), 32'd0);

    // Byte-wide instance: two bytes per 24-bit frame.
    @(negedge clk);
    rst2 = 1'b1;
    run2(0, 8'hA7, 16'h3C5A, 1'b0, 0, 0, 16'h0000, 8'd16);
    run2(1, 8'hA7, 16'h3C5A, 1'b1, 1, 2, 16'h3C5A, 8'd16);
    run2(2, 8'hA7, 16'hC381, 1'b1, 1, 2, 16'hC381, 8'd16);
    chk("w8_last_out", 32'(out2), 32'h81);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_sync_detector.md
FRAME_SYNC_DETECTOR -- requirements
Module: frame_sync_detector

Interface
REQ-001 The block SHALL have parameter SYNC_W, default 4, meaning sync word width in bits.
REQ-002 The block SHALL have parameter SYNC_PAT, default 4'b1001, meaning the sync pattern, MSB received first.
REQ-003 The block SHALL have parameter FRAME_LEN, default 16, meaning frame length in bits including sync; SYNC_W < FRAME_LEN <= 256.
REQ-004 The block SHALL have parameter WORD_W, default 4, meaning payload word width; (FRAME_LEN-SYNC_W) SHALL be a multiple of WORD_W.
REQ-005 The block SHALL have parameter CONFIRM, default 2, meaning consecutive expected-position sync hits needed to lock.
REQ-006 The block SHALL have parameter MISS, default 3, meaning consecutive expected-position sync misses needed to lose lock.
REQ-007 The block SHALL have port clk, input, 1, meaning the single clock, all state on rising edge.
REQ-008 The block SHALL have port reset, input, 1, meaning asynchronous, active-low reset.
REQ-009 The block SHALL have port in, input, 1, meaning the serial data bit, sampled every rising edge.
REQ-010 The block SHALL have port count, output, 8, meaning bit position within the frame.
REQ-011 The block SHALL have port frame, output, 1, meaning a one-cycle pulse on each accepted sync while locked.
REQ-012 The block SHALL have port out, output, WORD_W, meaning the last completed payload word.
REQ-013 The block SHALL have port out_valid, output, 1, meaning a one-cycle pulse when out is updated.
REQ-014 The block SHALL have port flag, output, 1, meaning high while the state is LOCK.

Function
REQ-015 The block SHALL shift `in` into an SYNC_W-bit register every edge, MSB-first; match = ({sr[SYNC_W-2:0],in} == SYNC_PAT), evaluated on the current edge.
REQ-016 The block SHALL implement states HUNT, VERIFY and LOCK.
REQ-017 In HUNT, on match the block SHALL set count <= 0 and hits <= 1, and go to VERIFY (or directly to LOCK if CONFIRM==1); with no match, count SHALL hold at 0.
REQ-018 In VERIFY and LOCK, count SHALL increment each edge and wrap from FRAME_LEN-1 to 0.
REQ-019 The expected sync check SHALL occur only on edges where count==FRAME_LEN-1; matches at other positions SHALL be ignored outside HUNT.
REQ-020 In VERIFY, a check hit SHALL increment hits, and reaching CONFIRM SHALL go to LOCK with misses <= 0; a check miss SHALL go to HUNT with count <= 0.
REQ-021 In LOCK, a check hit SHALL clear misses; a check miss SHALL increment misses, and reaching MISS SHALL go to HUNT with count <= 0.
REQ-022 frame SHALL be registered and pulse on the edge following a check hit that leaves or keeps the state in LOCK, including the VERIFY-to-LOCK entry.
REQ-023 In LOCK, bits sampled while count is in 0..FRAME_LEN-SYNC_W-1 SHALL be payload and shift MSB-first into a word register.
REQ-024 On a payload edge where count%WORD_W==WORD_W-1, the block SHALL load out <= {word[WORD_W-2:0],in} and pulse out_valid on the next cycle.
REQ-025 Payload SHALL NOT be emitted in HUNT or VERIFY; out SHALL hold its last value.
REQ-026 Leaving LOCK SHALL discard a partial word and drop flag in the same cycle the state changes.
REQ-027 A check miss and a simultaneous match at a non-expected position SHALL NOT cause resynchronisation until HUNT is re-entered.

Reset
REQ-028 While reset==0, state SHALL be HUNT and count, hits, misses, the shift register, word, out, out_valid, frame and flag SHALL all be 0.
REQ-029 Reset asserted mid-frame SHALL take effect immediately with no output pulse, and the first post-release edge SHALL behave as HUNT.

Structure
REQ-030 A shared package SHALL hold the state enum (HUNT/VERIFY/LOCK) and the count width constant (8).
REQ-031 The shift/compare logic SHALL be a sub-module named sync_matcher (parameters SYNC_W, SYNC_PAT; output match); the rest SHALL be in the top.

Verification
REQ-032 Defaults, stream of frames 1001 + payload A5C (hex, MSB first) -> after the 2nd sync flag=1; then each frame gives out=A, 5, C with out_valid pulses and one frame pulse.
REQ-033 Locked stream with one corrupted sync (1101) -> flag stays 1, no frame pulse that frame, misses=1, then cleared on the next good sync.
REQ-034 Locked stream, three consecutive corrupted syncs -> flag=0 on the 3rd miss, state HUNT, no out_valid until relock.
REQ-035 Payload containing 1001 during VERIFY/LOCK -> no realignment; during HUNT -> false lock attempt rejected at next check (VERIFY->HUNT).
REQ-036 Reset pulse low mid-payload while locked -> all outputs 0 immediately; relock after CONFIRM good frames.
REQ-037 FRAME_LEN=24, WORD_W=8, SYNC_PAT=8'hA7, SYNC_W=8 -> 2 bytes per frame, correct bytes after lock.
